// File: rtl/pcs25g_chk_defs.sv
// Shared definitions for the pcs25g decoder checker: lock-FSM state encodings
// and default parameter values.
package pcs25g_chk_defs;

    typedef enum logic [1:0] {
        CHK_IDLE   = 2'd0,
        CHK_SEARCH = 2'd1,
        CHK_LOCKED = 2'd2,
        CHK_FAIL   = 2'd3
    } chk_state_e;

    localparam int DEF_LOCK_CNT = 16;
    localparam int DEF_LOSS_CNT = 4;
    localparam int DEF_WIN_LEN  = 64;
    localparam int DEF_TMO      = 1024;
    localparam int DEF_ERRW     = 16;

endpackage

// File: rtl/chk_sat_cnt.sv
// Saturating event counter with synchronous clear; clear beats increment.
module chk_sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (inc_i && (cnt_q != {W{1'b1}}))
            cnt_d = cnt_q + W'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/chk_lock_ctrl.sv
// Lock sequencer for the pcs25g checker: IDLE -> SEARCH -> LOCKED, FAIL on
// search timeout, with windowed loss-of-lock detection and sticky statistics.
module chk_lock_ctrl
    import pcs25g_chk_defs::*;
#(
    parameter int LOCK_CNT = DEF_LOCK_CNT,
    parameter int LOSS_CNT = DEF_LOSS_CNT,
    parameter int WIN_LEN  = DEF_WIN_LEN,
    parameter int TMO      = DEF_TMO,
    parameter int ERRW     = DEF_ERRW
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic            clr_cnt,
    input  logic            in_valid,
    input  logic            in_sync,
    input  logic            correct,
    output logic            chk_en,
    output logic [1:0]      state,
    output logic            locked,
    output logic [ERRW-1:0] err_cnt,
    output logic [ERRW-1:0] loss_cnt,
    output logic            timeout
);

    localparam int RUN_W = $clog2(LOCK_CNT + 1);
    localparam int TMO_W = $clog2(TMO + 1);
    localparam int WIN_W = $clog2(WIN_LEN + 1);
    localparam int WE_W  = $clog2(LOSS_CNT + 1);

    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(LOCK_CNT - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO - 1);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_LEN - 1);
    localparam logic [WE_W-1:0]  WE_LAST  = WE_W'(LOSS_CNT - 1);

    chk_state_e       state_q;
    logic             chk_en_q, locked_q, timeout_q;
    logic [RUN_W-1:0] run_q;
    logic [TMO_W-1:0] tmo_q;
    logic [WIN_W-1:0] win_q;
    logic [WE_W-1:0]  werr_q;

    logic good, bad, lock_hit, tmo_hit, err_inc, loss_hit, fail_set;

    // in_sync is already folded into the checker's verdict on correct
    logic unused_in_sync;
    assign unused_in_sync = in_sync;

    assign good     = in_valid & correct;
    assign bad      = in_valid & ~correct;
    assign lock_hit = good & (run_q == RUN_LAST);
    assign tmo_hit  = (tmo_q == TMO_LAST);
    assign err_inc  = start & (state_q == CHK_LOCKED) & bad;
    assign loss_hit = err_inc & (werr_q == WE_LAST);
    assign fail_set = start & (state_q == CHK_SEARCH) & tmo_hit & ~lock_hit;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= CHK_IDLE;
            chk_en_q <= 1'b0;
            locked_q <= 1'b0;
            run_q    <= '0;
            tmo_q    <= '0;
            win_q    <= '0;
            werr_q   <= '0;
        end else if (!start) begin
            state_q  <= CHK_IDLE;
            chk_en_q <= 1'b0;
            locked_q <= 1'b0;
            run_q    <= '0;
            tmo_q    <= '0;
            win_q    <= '0;
            werr_q   <= '0;
        end else begin
            case (state_q)
                CHK_IDLE: begin
                    state_q  <= CHK_SEARCH;
                    chk_en_q <= 1'b1;
                end
                CHK_SEARCH: begin
                    tmo_q <= tmo_q + TMO_W'(1);
                    if (good)     run_q <= run_q + RUN_W'(1);
                    else if (bad) run_q <= '0;
                    // lock beats a timeout landing on the same cycle
                    if (lock_hit) begin
                        state_q  <= CHK_LOCKED;
                        locked_q <= 1'b1;
                        run_q    <= '0;
                        tmo_q    <= '0;
                        win_q    <= '0;
                        werr_q   <= '0;
                    end else if (tmo_hit) begin
                        state_q  <= CHK_FAIL;
                        chk_en_q <= 1'b0;
                        run_q    <= '0;
                        tmo_q    <= '0;
                    end
                end
                CHK_LOCKED: begin
                    if (in_valid) begin
                        if (loss_hit) begin
                            state_q  <= CHK_SEARCH;
                            locked_q <= 1'b0;
                            run_q    <= '0;
                            tmo_q    <= '0;
                            win_q    <= '0;
                            werr_q   <= '0;
                        end else if (win_q == WIN_LAST) begin
                            win_q  <= '0;
                            werr_q <= '0;
                        end else begin
                            win_q <= win_q + WIN_W'(1);
                            if (bad) werr_q <= werr_q + WE_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)      timeout_q <= 1'b0;
        else if (clr_cnt)  timeout_q <= 1'b0;
        else if (fail_set) timeout_q <= 1'b1;
    end

    chk_sat_cnt #(.W(ERRW)) u_err_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc_i   (err_inc),
        .clr_i   (clr_cnt),
        .cnt_o   (err_cnt)
    );

    chk_sat_cnt #(.W(ERRW)) u_loss_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc_i   (loss_hit),
        .clr_i   (clr_cnt),
        .cnt_o   (loss_cnt)
    );

    assign chk_en  = chk_en_q;
    assign state   = state_q;
    assign locked  = locked_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_chk_lock_ctrl.sv
// Directed bench for chk_lock_ctrl: a behavioural model checked every cycle,
// plus literal expectations at the end of each scenario.
module tb_chk_lock_ctrl;

    localparam int LOCK_CNT = 16;
    localparam int LOSS_CNT = 4;
    localparam int WIN_LEN  = 64;
    localparam int TMO      = 1024;
    // Narrow counters so saturation is reachable in a short run
    localparam int ERRW     = 8;
    localparam int MAXC     = (1 << ERRW) - 1;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            start = 1'b0, clr_cnt = 1'b0, in_valid = 1'b0;
    logic            in_sync = 1'b0, correct = 1'b0;
    logic            chk_en, locked, timeout;
    logic [1:0]      state;
    logic [ERRW-1:0] err_cnt, loss_cnt;

    chk_lock_ctrl #(
        .LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT), .WIN_LEN(WIN_LEN),
        .TMO(TMO), .ERRW(ERRW)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .clr_cnt  (clr_cnt),
        .in_valid (in_valid),
        .in_sync  (in_sync),
        .correct  (correct),
        .chk_en   (chk_en),
        .state    (state),
        .locked   (locked),
        .err_cnt  (err_cnt),
        .loss_cnt (loss_cnt),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0;
    bit cmp_en  = 1'b0;

    // Model: 0=IDLE 1=SEARCH 2=LOCKED 3=FAIL
    int m_state = 0, m_run = 0, m_tmo = 0, m_win = 0, m_werr = 0;
    int m_err = 0, m_loss = 0, m_timeout = 0;

    task automatic check(input string nm, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_run = 0; m_tmo = 0; m_win = 0; m_werr = 0;
        m_err = 0; m_loss = 0; m_timeout = 0;
    endtask

    task automatic model_step(input bit st, input bit clr, input bit v, input bit c);
        bit good, bad, err_i, loss_i, tmo_set;
        int ns;
        good = v && c; bad = v && !c;
        err_i = 0; loss_i = 0; tmo_set = 0;
        ns = m_state;
        if (!st) begin
            ns = 0; m_run = 0; m_tmo = 0; m_win = 0; m_werr = 0;
        end else if (m_state == 0) begin
            ns = 1;
        end else if (m_state == 1) begin
            m_tmo = m_tmo + 1;
            if (good) m_run = m_run + 1;
            if (bad)  m_run = 0;
            if (m_run == LOCK_CNT) begin
                ns = 2; m_run = 0; m_tmo = 0; m_win = 0; m_werr = 0;
            end else if (m_tmo == TMO) begin
                ns = 3; tmo_set = 1; m_run = 0; m_tmo = 0;
            end
        end else if (m_state == 2 && v) begin
            m_win = m_win + 1;
            if (bad) begin m_werr = m_werr + 1; err_i = 1; end
            if (m_werr == LOSS_CNT) begin
                ns = 1; loss_i = 1; m_run = 0; m_tmo = 0; m_win = 0; m_werr = 0;
            end else if (m_win == WIN_LEN) begin
                m_win = 0; m_werr = 0;
            end
        end
        m_state = ns;
        if (clr) begin
            m_err = 0; m_loss = 0; m_timeout = 0;
        end else begin
            if (err_i && m_err < MAXC)  m_err++;
            if (loss_i && m_loss < MAXC) m_loss++;
            if (tmo_set) m_timeout = 1;
        end
    endtask

    // One clock of stimulus; inputs settle before the edge, model follows it
    task automatic cyc(input bit st, input bit clr, input bit v, input bit c);
        start = st; clr_cnt = clr; in_valid = v; correct = c; in_sync = v & c;
        @(posedge clk);
        #1;
        if (reset_n) model_step(st, clr, v, c);
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check("state",    int'(state),    m_state);
            check("chk_en",   int'(chk_en),   int'(m_state == 1 || m_state == 2));
            check("locked",   int'(locked),   int'(m_state == 2));
            check("err_cnt",  int'(err_cnt),  m_err);
            check("loss_cnt", int'(loss_cnt), m_loss);
            check("timeout",  int'(timeout),  m_timeout);
        end
    end

    initial begin
        #12;
        check("rst_state", int'(state), 0);
        check("rst_outs", int'({chk_en, locked, timeout}), 0);
        check("rst_cnts", int'(err_cnt) + int'(loss_cnt), 0);
        reset_n = 1'b1;
        #1;
        cmp_en = 1'b1;

        // 1: lock after 16 consecutive good words
        cyc(1, 0, 0, 0);
        repeat (16) cyc(1, 0, 1, 1);
        check("t1_state", int'(state), 2);
        check("t1_locked", int'(locked), 1);
        check("t1_err", int'(err_cnt), 0);

        // 2: one bad word restarts the run
        cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        repeat (15) cyc(1, 0, 1, 1);
        cyc(1, 0, 1, 0);
        repeat (15) cyc(1, 0, 1, 1);
        check("t2_still_search", int'(state), 1);
        cyc(1, 0, 1, 1);
        check("t2_state", int'(state), 2);

        // 3: fourth bad word in one window drops lock
        for (int p = 1; p <= 30; p++)
            cyc(1, 0, 1, !(p == 1 || p == 10 || p == 20 || p == 30));
        check("t3_state", int'(state), 1);
        check("t3_loss", int'(loss_cnt), 1);
        check("t3_err", int'(err_cnt), 4);

        // 4: 3+3 errors split across a window boundary keep lock
        cyc(1, 1, 0, 0);
        repeat (16) cyc(1, 0, 1, 1);
        for (int p = 1; p <= 64; p++)
            cyc(1, 0, 1, !(p == 5 || p == 30 || p == 64));
        for (int p = 1; p <= 64; p++)
            cyc(1, 0, 1, !(p <= 3));
        check("t4_state", int'(state), 2);
        check("t4_err", int'(err_cnt), 6);
        check("t4_loss", int'(loss_cnt), 0);

        // 5: search timeout, sticky through IDLE, cleared by clr_cnt
        cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        repeat (TMO - 1) cyc(1, 0, 0, 0);
        check("t5_pre_fail", int'(state), 1);
        cyc(1, 0, 0, 0);
        check("t5_state", int'(state), 3);
        check("t5_timeout", int'(timeout), 1);
        check("t5_chk_en", int'(chk_en), 0);
        repeat (3) cyc(1, 0, 1, 1);
        check("t5_hold", int'(state), 3);
        cyc(0, 0, 0, 0);
        check("t5_idle", int'(state), 0);
        check("t5_sticky", int'(timeout), 1);
        cyc(0, 1, 0, 0);
        check("t5_clr", int'(timeout), 0);

        // 6: saturate both counters via repeated lock/loss
        cyc(1, 0, 0, 0);
        for (int k = 0; k < 260; k++) begin
            repeat (16) cyc(1, 0, 1, 1);
            repeat (4) cyc(1, 0, 1, 0);
        end
        check("t6_err_sat", int'(err_cnt), MAXC);
        check("t6_loss_sat", int'(loss_cnt), MAXC);
        repeat (16) cyc(1, 0, 1, 1);
        cyc(1, 1, 1, 0);
        check("t6_clr_err", int'(err_cnt), 0);
        check("t6_clr_loss", int'(loss_cnt), 0);
        check("t6_clr_state", int'(state), 2);
        cyc(1, 0, 1, 0);
        check("t6_err_one", int'(err_cnt), 1);

        // async reset mid-LOCKED
        #2;
        reset_n = 1'b0;
        #1;
        check("ar_state", int'(state), 0);
        check("ar_outs", int'({chk_en, locked, timeout}), 0);
        check("ar_err", int'(err_cnt), 0);
        model_reset();
        #3;
        reset_n = 1'b1;
        cyc(0, 0, 1, 1);
        check("ar_wait", int'(state), 0);
        cyc(1, 0, 1, 1);
        check("ar_restart", int'(state), 1);

        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
